usb_txn_ctrl: RTL
=================

# usb_txn_ctrl

Host-side USB transaction sequencer sitting above the packet transmit pipeline (`pipeOut`) and receive pipeline (`pipeIn`). It takes one OUT or IN request from a requester, drives the token, data and handshake packets in order, and owns the bus direction (`writing`). It interprets ACK/NAK/error/timeout and retries a transaction up to a fixed limit before reporting the result.

## Interface
- `MAX_TRIES`, default 8: total attempts per transaction, including the first; range 1..15.
- `TIMEOUT`, default 255: receive wait limit, in cycles; range 1..255.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `txn_start`  in  1  one-cycle request pulse; accepted only in IDLE.
- `txn_in`  in  1  transaction kind: 1 = IN, 0 = OUT. Sampled with `txn_start`.
- `txn_addr`  in  7  device address. Sampled with `txn_start`.
- `txn_endp`  in  4  endpoint. Sampled with `txn_start`.
- `txn_wdata`  in  64  OUT payload. Sampled with `txn_start`.
- `busy`  out  1  high from acceptance until the cycle after `txn_done`.
- `txn_done`  out  1  one-cycle completion pulse.
- `txn_ok`  out  1  result qualifier, valid with `txn_done`: 1 = success.
- `txn_rdata`  out  64  IN payload; valid with `txn_done` when `txn_ok` = 1; holds until the next `txn_done`.
- `pid`  out  4  PID to transmit.
- `endp`  out  4  endpoint field to transmit.
- `addr`  out  7  address field to transmit.
- `data`  out  64  payload to transmit.
- `pkttype`  out  1  packet type: 0 = token/handshake, 1 = data.
- `pktready_bs`  out  1  one-cycle send strobe to the transmit pipeline.
- `sending_usb`  in  1  transmit pipeline is driving the bus.
- `writing`  out  1  bus direction: host owns the bus; receive pipeline is disabled.
- `rx_data`  in  64  received payload from the receive pipeline.
- `rx_pktready`  in  1  received data packet is valid.
- `rx_error`  in  1  receive pipeline reports a CRC or PID error.
- `rx_ack`  in  1  ACK handshake received.
- `rx_nak`  in  1  NAK handshake received.

## Operation
- PID constants: OUT = 0001, IN = 1001, DATA0 = 0011, ACK = 0010, NAK = 1010.
- FSM states: IDLE, TX_TOK, WT_TOK, TX_DATA, WT_DATA, RX_HS, RX_DATA, TX_HS, WT_HS, DONE.
- IDLE:
  - `txn_start` latches all request fields and clears the try counter.
  - → TX_TOK.
- TX_TOK:
  - Drive the token: `pid` = OUT or IN, `pkttype` = 0, the latched addr/endp.
  - Pulse `pktready_bs`; set `writing`.
  - → WT_TOK.
- WT_TOK: wait for a falling edge of `sending_usb`.
  - OUT → TX_DATA.
  - IN → RX_DATA: clear `writing`, clear the timer.
- TX_DATA:
  - `pid` = DATA0, `pkttype` = 1, `data` = latched wdata.
  - Pulse `pktready_bs`.
  - → WT_DATA.
- WT_DATA: wait for a falling edge of `sending_usb`; clear `writing`, clear the timer; → RX_HS.
- RX_HS (OUT only):
  - `rx_ack` → DONE, ok = 1.
  - `rx_nak`, `rx_error` or timer = TIMEOUT → retry.
- RX_DATA (IN only):
  - `rx_pktready` with no `rx_error`: capture `rx_data`, set hs = ACK, → TX_HS.
  - `rx_error` or timeout: set hs = NAK, → TX_HS.
  - `rx_nak` from the device: → retry.
- TX_HS:
  - `pid` = hs, `pkttype` = 0; set `writing`; pulse `pktready_bs`.
  - → WT_HS.
- WT_HS: on a falling edge of `sending_usb`:
  - if hs = ACK → DONE, ok = 1;
  - otherwise → retry.
- Retry:
  - Increment tries.
  - If tries = MAX_TRIES → DONE, ok = 0.
  - Otherwise → TX_TOK.
- DONE: pulse `txn_done`; drive `txn_ok`; → IDLE.
- Simultaneous receive events:
  - Priority is `rx_error` > `rx_ack`/`rx_pktready` > `rx_nak` > timeout.
  - Receive inputs are ignored while `writing` = 1.
- Timer:
  - 8-bit; increments each cycle in RX_HS/RX_DATA.
  - Saturates at TIMEOUT.

## Timing
- Reset values: all outputs 0; state IDLE; `txn_rdata` 0.
- Send fields (`pid`, `addr`, `endp`, `data`, `pkttype`) are registered.
- Send fields are stable from the `pktready_bs` cycle until `sending_usb` falls.
- `sending_usb` edge detection is registered: the state advances in the cycle after 1→0 is observed.
- `pktready_bs` is exactly one cycle long, one per packet.
- Latencies:
  - `txn_start` → `pktready_bs` (token): 2 cycles.
  - `rx_ack` → `txn_done`: 2 cycles.
- A `txn_start` that arrives while busy is dropped. No queueing.
- Reset mid-transaction:
  - Returns to IDLE immediately.
  - Deasserts `writing` and `pktready_bs`.
  - No `txn_done` is generated.

## Structure
- Package `usb_pkg`: PID constants, `pkttype` encoding, the FSM state enum.
- Optional sub-module `usb_rx_timer`: clear/enable/saturating counter with a `timeout` output.
- Everything else is a single FSM plus datapath registers in `usb_txn_ctrl`.

## Test plan
- OUT, addr = 05, endp = 1, wdata = 0xDEADBEEF_01234567; responder ACKs.
  - Required: two `pktready_bs` pulses with PIDs 0001 then 0011.
  - Required: `txn_done` with `txn_ok` = 1; tries = 1.
- OUT; responder NAKs twice, then ACKs.
  - Required: 3 token + 3 data sends, then `txn_ok` = 1.
- IN; device returns 0x0123_4567_89AB_CDEF.
  - Required: ACK (0010) sent, `txn_rdata` equals the payload, `txn_ok` = 1.
- IN; device returns `rx_error` on every try, with MAX_TRIES = 3.
  - Required: 3 NAK handshakes sent, then `txn_done` with `txn_ok` = 0.
- OUT; no response ever.
  - Required: each attempt times out 255 cycles after `writing` falls.
  - Required: 8 attempts, then `txn_ok` = 0.
- Assert `rst` during WT_DATA.
  - Required: outputs are 0 in the same cycle and there is no `txn_done`.
  - Required: a new `txn_start` afterwards completes normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared encodings for the host USB transaction sequencer: PIDs, packet
// type and the controller state enum.
package usb_pkg;
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic PKT_TOKHS = 1'b0;
    localparam logic PKT_DATA  = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE, S_TX_TOK, S_WT_TOK, S_TX_DATA, S_WT_DATA,
        S_RX_HS, S_RX_DATA, S_TX_HS, S_WT_HS, S_DONE
    } state_e;
endpackage

// File: rtl/usb_rx_timer.sv
// Receive-wait timer: clear has priority, counts while enabled and
// saturates at TIMEOUT, which is also the timeout indication.
module usb_rx_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);
    logic [7:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   cnt_q <= '0;
        else if (clr_i)                            cnt_q <= '0;
        else if (en_i && cnt_q != 8'(TIMEOUT))     cnt_q <= cnt_q + 8'd1;
    end

    assign timeout_o = (cnt_q == 8'(TIMEOUT));
endmodule

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: issues token/data/handshake packets
// for one OUT or IN request, owns bus direction and retries on failure.
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txn_start,
    input  logic        txn_in,
    input  logic [6:0]  txn_addr,
    input  logic [3:0]  txn_endp,
    input  logic [63:0] txn_wdata,
    output logic        busy,
    output logic        txn_done,
    output logic        txn_ok,
    output logic [63:0] txn_rdata,
    output logic [3:0]  pid,
    output logic [3:0]  endp,
    output logic [6:0]  addr,
    output logic [63:0] data,
    output logic        pkttype,
    output logic        pktready_bs,
    input  logic        sending_usb,
    output logic        writing,
    input  logic [63:0] rx_data,
    input  logic        rx_pktready,
    input  logic        rx_error,
    input  logic        rx_ack,
    input  logic        rx_nak
);
    state_e      state_q, state_d;
    logic        is_in_q, is_in_d;
    logic [6:0]  req_addr_q, req_addr_d;
    logic [3:0]  req_endp_q, req_endp_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  tries_q, tries_d;
    logic        hs_ack_q, hs_ack_d;
    logic        res_ok_q, res_ok_d;
    logic [63:0] rbuf_q, rbuf_d;
    logic [3:0]  pid_q, pid_d;
    logic [3:0]  endp_q, endp_d;
    logic [6:0]  addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic        ptype_q, ptype_d;
    logic        prdy_q, prdy_d;
    logic        writing_q, writing_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [63:0] rdata_q, rdata_d;
    logic        sending_q;
    logic        fall, rx_state, timeout, retry;
    logic        e_err, e_ack, e_pkt, e_nak;

    // Falling edge of sending_usb, using the previous-cycle sample.
    assign fall     = sending_q & ~sending_usb;
    assign rx_state = (state_q == S_RX_HS) || (state_q == S_RX_DATA);
    // Receive pipeline is disabled while the host owns the bus.
    assign e_err = rx_error    & ~writing_q;
    assign e_ack = rx_ack      & ~writing_q;
    assign e_pkt = rx_pktready & ~writing_q;
    assign e_nak = rx_nak      & ~writing_q;

    usb_rx_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (~rx_state),
        .en_i      (rx_state),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d    = state_q;
        is_in_d    = is_in_q;
        req_addr_d = req_addr_q;
        req_endp_d = req_endp_q;
        wdata_d    = wdata_q;
        tries_d    = tries_q;
        hs_ack_d   = hs_ack_q;
        res_ok_d   = res_ok_q;
        rbuf_d     = rbuf_q;
        pid_d      = pid_q;
        endp_d     = endp_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ptype_d    = ptype_q;
        prdy_d     = 1'b0;
        writing_d  = writing_q;
        busy_d     = done_q ? 1'b0 : busy_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        rdata_d    = rdata_q;
        retry      = 1'b0;

        case (state_q)
            S_IDLE: if (txn_start && !busy_q) begin
                is_in_d    = txn_in;
                req_addr_d = txn_addr;
                req_endp_d = txn_endp;
                wdata_d    = txn_wdata;
                tries_d    = '0;
                busy_d     = 1'b1;
                state_d    = S_TX_TOK;
            end
            S_TX_TOK: begin
                pid_d     = is_in_q ? PID_IN : PID_OUT;
                ptype_d   = PKT_TOKHS;
                addr_d    = req_addr_q;
                endp_d    = req_endp_q;
                prdy_d    = 1'b1;
                writing_d = 1'b1;
                state_d   = S_WT_TOK;
            end
            S_WT_TOK: if (fall) begin
                if (is_in_q) begin
                    writing_d = 1'b0;
                    state_d   = S_RX_DATA;
                end else begin
                    state_d   = S_TX_DATA;
                end
            end
            S_TX_DATA: begin
                pid_d   = PID_DATA0;
                ptype_d = PKT_DATA;
                data_d  = wdata_q;
                prdy_d  = 1'b1;
                state_d = S_WT_DATA;
            end
            S_WT_DATA: if (fall) begin
                writing_d = 1'b0;
                state_d   = S_RX_HS;
            end
            S_RX_HS: begin
                if (e_err)                 retry = 1'b1;
                else if (e_ack) begin
                    res_ok_d = 1'b1;
                    state_d  = S_DONE;
                end
                else if (e_nak || timeout) retry = 1'b1;
            end
            S_RX_DATA: begin
                if (e_err) begin
                    hs_ack_d = 1'b0;
                    state_d  = S_TX_HS;
                end else if (e_pkt) begin
                    rbuf_d   = rx_data;
                    hs_ack_d = 1'b1;
                    state_d  = S_TX_HS;
                end else if (e_nak) begin
                    retry    = 1'b1;
                end else if (timeout) begin
                    hs_ack_d = 1'b0;
                    state_d  = S_TX_HS;
                end
            end
            S_TX_HS: begin
                pid_d     = hs_ack_q ? PID_ACK : PID_NAK;
                ptype_d   = PKT_TOKHS;
                prdy_d    = 1'b1;
                writing_d = 1'b1;
                state_d   = S_WT_HS;
            end
            S_WT_HS: if (fall) begin
                if (hs_ack_q) begin
                    res_ok_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    retry    = 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                ok_d    = res_ok_q;
                if (res_ok_q && is_in_q) rdata_d = rbuf_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (retry) begin
            tries_d = tries_q + 4'd1;
            if (tries_d == 4'(MAX_TRIES)) begin
                res_ok_d = 1'b0;
                state_d  = S_DONE;
            end else begin
                state_d  = S_TX_TOK;
            end
        end
        if (state_d == S_DONE) writing_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_in_q    <= 1'b0;
            req_addr_q <= '0;
            req_endp_q <= '0;
            wdata_q    <= '0;
            tries_q    <= '0;
            hs_ack_q   <= 1'b0;
            res_ok_q   <= 1'b0;
            rbuf_q     <= '0;
            pid_q      <= '0;
            endp_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ptype_q    <= 1'b0;
            prdy_q     <= 1'b0;
            writing_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            rdata_q    <= '0;
            sending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_in_q    <= is_in_d;
            req_addr_q <= req_addr_d;
            req_endp_q <= req_endp_d;
            wdata_q    <= wdata_d;
            tries_q    <= tries_d;
            hs_ack_q   <= hs_ack_d;
            res_ok_q   <= res_ok_d;
            rbuf_q     <= rbuf_d;
            pid_q      <= pid_d;
            endp_q     <= endp_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            ptype_q    <= ptype_d;
            prdy_q     <= prdy_d;
            writing_q  <= writing_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            rdata_q    <= rdata_d;
            sending_q  <= sending_usb;
        end
    end

    assign busy        = busy_q;
    assign txn_done    = done_q;
    assign txn_ok      = ok_q;
    assign txn_rdata   = rdata_q;
    assign pid         = pid_q;
    assign endp        = endp_q;
    assign addr        = addr_q;
    assign data        = data_q;
    assign pkttype     = ptype_q;
    assign pktready_bs = prdy_q;
    assign writing     = writing_q;
endmodule
